id_operand_stage: RTL and testbench
===================================

# id_operand_stage

Decode and operand-fetch stage of the RV32I pipeline, between the fetch stage and the execute stage. Decodes each instruction, drives the register file read addresses, bypasses same-cycle writebacks, and holds a per-register busy scoreboard for RAW/WAW hazard stalls. Issued instructions are latched into the ID/EX pipeline register behind a valid/ready handshake.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREGS, 32, architectural registers (x0 hardwired to zero)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage accepts the instruction this cycle
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction address
- rf_raddr1, rf_raddr2  out  5  register file read addresses (combinational from if_instr[19:15], [24:20])
- rf_rdata1, rf_rdata2  in  XLEN  register file read data (combinational, pre-write value)
- wb_valid  in  1  writeback this cycle (same strobe drives register file regwrite)
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- flush  in  1  kill instruction held in ID/EX; block issue this cycle
- ex_valid  out  1  ID/EX register holds an instruction
- ex_ready  in  1  execute consumes ID/EX this cycle
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN  latched PC, operands, sign-extended immediate
- ex_rd  out  5  destination register
- ex_opcode  out  7; ex_funct3  out  3; ex_funct7b5  out  1  decode fields
- ex_regwrite  out  1  instruction writes rd (0 when rd==x0)
- ex_illegal  out  1  unsupported opcode

## Operation
- Opcode classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Any other opcode: ex_illegal=1, regwrite=0, uses no sources.
- use_rs1: all classes except LUI/AUIPC/JAL. use_rs2: OP, STORE, BRANCH. regwrite: all except STORE/BRANCH, and forced 0 when rd==0.
- Immediate: I (LOAD, OP-IMM, JALR), S, B, U, J formats, sign-extended to XLEN; B/J bit 0 = 0.
- Operand select per source: rs==0 -> 0; else wb_valid && wb_rd==rs -> wb_data; else rf_rdata.
- Scoreboard busy[NREGS-1:1]; busy[0] constant 0.
  - clear_pending(r) = busy[r] && !(wb_valid && wb_rd==r).
  - hazard = (use_rs1 && clear_pending(rs1)) || (use_rs2 && clear_pending(rs2)) || (regwrite && clear_pending(rd)).
  - WAW stall guarantees at most one outstanding write per register.
- slot_free = !ex_valid || ex_ready.
- if_ready = slot_free && !hazard && !flush.
- issue = if_valid && if_ready: ID/EX loads all fields, ex_valid<=1; busy[rd] set if regwrite.
- slot_free && !issue: ex_valid<=0; payload fields hold.
- Scoreboard per cycle: wb_valid clears busy[wb_rd]; issue sets busy[rd]; set wins on same register.
- flush: ex_valid<=0; if ex_valid && ex_regwrite, busy[ex_rd] cleared (killed write never returns). No issue that cycle, regardless of if_valid.
- Writeback to x0 ignored by scoreboard.

## Timing
- Latency: 1 cycle, if acceptance to ex_valid.
- Reset (async assert, synchronous-edge release): ex_valid=0, all ex_* payloads 0, busy all 0. if_ready evaluates to 1 with no hazard.
- Reset mid-stall: pending instruction dropped; fetch must re-present.
- Back-to-back: ex_ready held 1, independent instructions -> one issue per cycle.
- Dependent instruction directly behind a producer: stalls until the cycle wb_valid carries that rd. Issues in that same cycle with the bypassed wb_data.
- Payload stable while ex_valid && !ex_ready.
- Simultaneous flush and wb to the killed rd: busy cleared (both clear).

## Structure
- Shared package rv_pkg:
  - opcode localparams
  - imm_type_e enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}
  - decode field widths
- Sub-module rv_imm_gen: combinational instr -> imm_type, imm. Reused by the fetch stage branch predictor.
- Scoreboard, bypass and ID/EX register stay in this module.

## Test plan
- Reset with if_valid=1 -> ex_valid=0, busy=0, all ex_* 0. After release, ADDI x1,x0,5 issues; next cycle ex_valid=1, ex_rd=1, ex_imm=5, ex_regwrite=1.
- ADDI x1 then ADD x2,x1,x1 (no writeback) -> if_ready=0. At wb_valid wb_rd=1 wb_data=0x5, ADD issues same cycle with ex_rs1_val=ex_rs2_val=0x5.
- ex_ready=0 for 3 cycles with ex_valid=1 -> payload unchanged, if_ready=0. Release -> next instruction captured next edge.
- flush while ex holds LW x3 -> ex_valid=0, busy[3]=0. Following ADD x4,x3,x0 issues immediately using rf_rdata1.
- Writes to x0 (ADDI x0,x0,1) -> ex_regwrite=0, no busy bit. Dependent reader of x0 gets 0 without stall.
- Illegal opcode 0x0000007F -> ex_illegal=1, ex_regwrite=0, no stall. Immediates: SW imm=-4 -> ex_imm=0xFFFFFFFC; JAL imm=+2048 -> 0x00000800.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: RV32I opcodes, decode field widths and immediate format types.
package rv_pkg;
   localparam int OPCODE_W = 7;
   localparam int REG_W    = 5;
   localparam int FUNCT3_W = 3;
   localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OP_OP     = 7'b0110011;
   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;
endpackage

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: classifies the immediate format of an instruction and sign-extends it to XLEN.
module rv_imm_gen
   import rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instr,
   output imm_type_e       o_imm_type,
   output logic [XLEN-1:0] o_imm
);
   logic [31:0] w_i;
   logic [31:0] w_imm32;
   assign w_i = i_instr;
   always_comb begin
      case (w_i[6:0])
         OP_LOAD, OP_IMM, OP_JALR: o_imm_type = IMM_I;
         OP_STORE:                 o_imm_type = IMM_S;
         OP_BRANCH:                o_imm_type = IMM_B;
         OP_LUI, OP_AUIPC:         o_imm_type = IMM_U;
         OP_JAL:                   o_imm_type = IMM_J;
         default:                  o_imm_type = IMM_NONE;
      endcase
   end
   assign w_imm32 =
      (o_imm_type == IMM_I) ? {{20{w_i[31]}}, w_i[31:20]} :
      (o_imm_type == IMM_S) ? {{20{w_i[31]}}, w_i[31:25], w_i[11:7]} :
      (o_imm_type == IMM_B) ? {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0} :
      (o_imm_type == IMM_U) ? {w_i[31:12], 12'b0} :
      (o_imm_type == IMM_J) ? {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0} :
      32'b0;
   assign o_imm = XLEN'($signed(w_imm32));
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: RV32I decode/operand fetch with writeback bypass, busy scoreboard
// and a valid/ready ID/EX pipeline register.
module id_operand_stage
   import rv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_valid,
   output logic                if_ready,
   input  logic [31:0]         if_instr,
   input  logic [XLEN-1:0]     if_pc,
   output logic [REG_W-1:0]    rf_raddr1,
   output logic [REG_W-1:0]    rf_raddr2,
   input  logic [XLEN-1:0]     rf_rdata1,
   input  logic [XLEN-1:0]     rf_rdata2,
   input  logic                wb_valid,
   input  logic [REG_W-1:0]    wb_rd,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                flush,
   output logic                ex_valid,
   input  logic                ex_ready,
   output logic [XLEN-1:0]     ex_pc,
   output logic [XLEN-1:0]     ex_rs1_val,
   output logic [XLEN-1:0]     ex_rs2_val,
   output logic [XLEN-1:0]     ex_imm,
   output logic [REG_W-1:0]    ex_rd,
   output logic [OPCODE_W-1:0] ex_opcode,
   output logic [FUNCT3_W-1:0] ex_funct3,
   output logic                ex_funct7b5,
   output logic                ex_regwrite,
   output logic                ex_illegal
);
   logic [OPCODE_W-1:0] w_opcode;
   logic [REG_W-1:0]    w_rd, w_rs1, w_rs2;
   imm_type_e           w_imm_type;
   logic [XLEN-1:0]     w_imm, w_rs1_val, w_rs2_val;
   logic                w_legal, w_use_rs1, w_use_rs2, w_regwrite;
   logic                w_hazard, w_slot_free, w_issue;
   logic [NREGS-1:0]    r_busy, w_wb_mask, w_kill_mask, w_set_mask, w_pend, w_busy_nxt;
   assign w_opcode  = if_instr[6:0];
   assign w_rd      = if_instr[11:7];
   assign w_rs1     = if_instr[19:15];
   assign w_rs2     = if_instr[24:20];
   assign rf_raddr1 = w_rs1;
   assign rf_raddr2 = w_rs2;
   rv_imm_gen #(.XLEN(XLEN)) u_imm (
      .i_instr    (if_instr),
      .o_imm_type (w_imm_type),
      .o_imm      (w_imm)
   );
   // Every legal class except OP carries an immediate, so the format doubles as the decoder.
   assign w_legal    = (w_imm_type != IMM_NONE) || (w_opcode == OP_OP);
   assign w_use_rs1  = w_legal && !(w_imm_type inside {IMM_U, IMM_J});
   assign w_use_rs2  = (w_imm_type inside {IMM_S, IMM_B}) || (w_opcode == OP_OP);
   assign w_regwrite = w_legal && !(w_imm_type inside {IMM_S, IMM_B}) && (w_rd != '0);
   assign w_rs1_val  = (w_rs1 == '0) ? '0 : (wb_valid && wb_rd == w_rs1) ? wb_data : rf_rdata1;
   assign w_rs2_val  = (w_rs2 == '0) ? '0 : (wb_valid && wb_rd == w_rs2) ? wb_data : rf_rdata2;
   assign w_wb_mask   = wb_valid ? (NREGS'(1) << wb_rd) : '0;
   assign w_kill_mask = (flush && ex_valid && ex_regwrite) ? (NREGS'(1) << ex_rd) : '0;
   assign w_pend      = r_busy & ~w_wb_mask;
   assign w_hazard    = (w_use_rs1 && w_pend[w_rs1]) || (w_use_rs2 && w_pend[w_rs2]) ||
                        (w_regwrite && w_pend[w_rd]);
   assign w_slot_free = !ex_valid || ex_ready;
   assign if_ready    = w_slot_free && !w_hazard && !flush;
   assign w_issue     = if_valid && if_ready;
   assign w_set_mask  = (w_issue && w_regwrite) ? (NREGS'(1) << w_rd) : '0;
   assign w_busy_nxt  = ((r_busy & ~w_wb_mask & ~w_kill_mask) | w_set_mask) & ~NREGS'(1);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy      <= '0;
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1_val  <= '0;
         ex_rs2_val  <= '0;
         ex_imm      <= '0;
         ex_rd       <= '0;
         ex_opcode   <= '0;
         ex_funct3   <= '0;
         ex_funct7b5 <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_illegal  <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         if (w_issue) begin
            ex_valid    <= 1'b1;
            ex_pc       <= if_pc;
            ex_rs1_val  <= w_rs1_val;
            ex_rs2_val  <= w_rs2_val;
            ex_imm      <= w_imm;
            ex_rd       <= w_rd;
            ex_opcode   <= w_opcode;
            ex_funct3   <= if_instr[14:12];
            ex_funct7b5 <= if_instr[30];
            ex_regwrite <= w_regwrite;
            ex_illegal  <= !w_legal;
         end else if (w_slot_free || flush) begin
            ex_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed vectors with hand-computed expectations for id_operand_stage.
module tb_id_operand_stage;
   logic        clk = 1'b0, reset = 1'b1;
   logic        if_valid = 1'b0, if_ready;
   logic [31:0] if_instr = '0, if_pc = '0;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        flush = 1'b0, ex_valid, ex_ready = 1'b1;
   logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
   logic [4:0]  ex_rd;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic        ex_funct7b5, ex_regwrite, ex_illegal;
   logic [31:0] rf [32];
   int          n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   id_operand_stage dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .wb_data(wb_data), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
      .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
      .ex_regwrite(ex_regwrite), .ex_illegal(ex_illegal)
   );

   // Register file model: x0 deliberately nonzero so the stage must force zero itself.
   assign rf_rdata1 = rf[rf_raddr1];
   assign rf_rdata2 = rf[rf_raddr2];
   always @(posedge clk) if (wb_valid && wb_rd != 5'd0) rf[wb_rd] <= wb_data;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
      if_valid = 1'b1;
      if_instr = ins;
      if_pc    = pc;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
      drive(32'h00500093, 32'h100);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("rst_busy", dut.r_busy, 32'd0);
      chk("rst_ex_rd", {27'b0, ex_rd}, 32'd0);
      chk("rst_ex_imm", ex_imm, 32'd0);
      chk("rst_ex_pc", ex_pc, 32'd0);
      chk("rst_if_ready", {31'b0, if_ready}, 32'd1);
      reset = 1'b0;
      step;
      chk("addi_valid", {31'b0, ex_valid}, 32'd1);
      chk("addi_rd", {27'b0, ex_rd}, 32'd1);
      chk("addi_imm", ex_imm, 32'd5);
      chk("addi_regwrite", {31'b0, ex_regwrite}, 32'd1);
      chk("addi_pc", ex_pc, 32'h100);
      chk("addi_busy", dut.r_busy, 32'h2);
      // RAW stall on x1 until its writeback, then bypass
      drive(32'h00108133, 32'h104);
      #1;
      chk("raw_stall_ready", {31'b0, if_ready}, 32'd0);
      step;
      chk("raw_bubble", {31'b0, ex_valid}, 32'd0);
      chk("raw_hold_rd", {27'b0, ex_rd}, 32'd1);
      wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h5;
      #1;
      chk("raw_wb_ready", {31'b0, if_ready}, 32'd1);
      step;
      wb_valid = 1'b0;
      chk("byp_rs1", ex_rs1_val, 32'h5);
      chk("byp_rs2", ex_rs2_val, 32'h5);
      chk("byp_rd", {27'b0, ex_rd}, 32'd2);
      chk("byp_busy", dut.r_busy, 32'h4);
      // Back-pressure holds the payload
      ex_ready = 1'b0;
      drive(32'h123453B7, 32'h200);
      #1;
      chk("bp_ready", {31'b0, if_ready}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         step;
         chk("bp_valid", {31'b0, ex_valid}, 32'd1);
         chk("bp_rd", {27'b0, ex_rd}, 32'd2);
         chk("bp_rs1", ex_rs1_val, 32'h5);
         chk("bp_ready", {31'b0, if_ready}, 32'd0);
      end
      ex_ready = 1'b1;
      #1;
      chk("bp_rel_ready", {31'b0, if_ready}, 32'd1);
      step;
      chk("lui_rd", {27'b0, ex_rd}, 32'd7);
      chk("lui_imm", ex_imm, 32'h12345000);
      chk("lui_pc", ex_pc, 32'h200);
      chk("lui_opcode", {25'b0, ex_opcode}, 32'h37);
      // Flush kills LW x3 and frees its busy bit
      drive(32'h00002183, 32'h204);
      step;
      chk("lw_rd", {27'b0, ex_rd}, 32'd3);
      chk("lw_funct3", {29'b0, ex_funct3}, 32'd2);
      chk("lw_busy", dut.r_busy, 32'h8C);
      ex_ready = 1'b0; flush = 1'b1;
      drive(32'h00018233, 32'h208);
      #1;
      chk("flush_ready", {31'b0, if_ready}, 32'd0);
      step;
      flush = 1'b0;
      chk("flush_valid", {31'b0, ex_valid}, 32'd0);
      chk("flush_busy", dut.r_busy, 32'h84);
      ex_ready = 1'b1;
      #1;
      chk("post_flush_ready", {31'b0, if_ready}, 32'd1);
      step;
      chk("post_flush_rs1", ex_rs1_val, 32'h1003);
      chk("post_flush_rs2", ex_rs2_val, 32'd0);
      chk("post_flush_rd", {27'b0, ex_rd}, 32'd4);
      // Writes to and reads from x0
      drive(32'h00100013, 32'h20C);
      step;
      chk("x0_regwrite", {31'b0, ex_regwrite}, 32'd0);
      chk("x0_busy", dut.r_busy, 32'h94);
      drive(32'h000002B3, 32'h210);
      #1;
      chk("x0_read_ready", {31'b0, if_ready}, 32'd1);
      step;
      chk("x0_rs1", ex_rs1_val, 32'd0);
      chk("x0_rs2", ex_rs2_val, 32'd0);
      chk("x0_rd", {27'b0, ex_rd}, 32'd5);
      // Back-to-back: illegal, SW, JAL, BEQ
      drive(32'h0000007F, 32'h214);
      #1;
      chk("ill_ready", {31'b0, if_ready}, 32'd1);
      step;
      chk("ill_flag", {31'b0, ex_illegal}, 32'd1);
      chk("ill_regwrite", {31'b0, ex_regwrite}, 32'd0);
      drive(32'hFE002E23, 32'h218);
      step;
      chk("sw_valid", {31'b0, ex_valid}, 32'd1);
      chk("sw_imm", ex_imm, 32'hFFFFFFFC);
      chk("sw_regwrite", {31'b0, ex_regwrite}, 32'd0);
      chk("sw_illegal", {31'b0, ex_illegal}, 32'd0);
      drive(32'h0010036F, 32'h21C);
      step;
      chk("jal_imm", ex_imm, 32'h00000800);
      chk("jal_rd", {27'b0, ex_rd}, 32'd6);
      chk("jal_regwrite", {31'b0, ex_regwrite}, 32'd1);
      drive(32'hFE000CE3, 32'h220);
      step;
      chk("beq_imm", ex_imm, 32'hFFFFFFF8);
      chk("beq_busy", dut.r_busy, 32'hF4);
      // Flush and writeback to the killed rd in the same cycle
      drive(32'h00100413, 32'h224);
      step;
      chk("x8_busy", dut.r_busy, 32'h1F4);
      if_valid = 1'b0; flush = 1'b1;
      wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 32'h77;
      step;
      flush = 1'b0; wb_valid = 1'b0;
      chk("fwb_valid", {31'b0, ex_valid}, 32'd0);
      chk("fwb_busy", dut.r_busy, 32'hF4);
      // Reset while stalled on x4
      drive(32'h004204B3, 32'h300);
      #1;
      chk("mid_stall_ready", {31'b0, if_ready}, 32'd0);
      step;
      chk("mid_stall_valid", {31'b0, ex_valid}, 32'd0);
      reset = 1'b1;
      #1;
      chk("arst_busy", dut.r_busy, 32'd0);
      chk("arst_pc", ex_pc, 32'd0);
      chk("arst_imm", ex_imm, 32'd0);
      #3;
      reset = 1'b0;
      #1;
      chk("rerun_ready", {31'b0, if_ready}, 32'd1);
      step;
      chk("rerun_valid", {31'b0, ex_valid}, 32'd1);
      chk("rerun_rd", {27'b0, ex_rd}, 32'd9);
      chk("rerun_rs1", ex_rs1_val, 32'h1004);
      chk("rerun_busy", dut.r_busy, 32'h200);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
